// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, ALU function codes, lock limit.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b110;
    localparam logic [2:0] F_SLT = 3'b111;

    localparam int LOCK_MAX = 4;

    function automatic int wrap_inc(input int idx, input int num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU: f[2] inverts B (with carry-in), f[1:0] picks AND/OR/SUM/SLT.
// Latency: 0 cycles. Backpressure: none.
// Overflow is reported for SUM only; SLT is a true signed compare.
module alu
    import alu_arb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   f,
    output logic [N-1:0] y,
    output logic         o,
    output logic         z
);

    logic [N-1:0] bb;
    logic [N-1:0] sum;
    logic         ovf;

    assign bb  = f[2] ? ~b : b;
    assign sum = a + bb + {{(N-1){1'b0}}, f[2]};
    assign ovf = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]);

    always_comb begin
        y = '0;
        o = 1'b0;
        case (f[1:0])
            F_AND[1:0]: y = a & bb;
            F_OR[1:0]:  y = a | bb;
            F_ADD[1:0]: begin
                y = sum;
                o = ovf;
            end
            default:    y = {{(N-1){1'b0}}, sum[N-1] ^ ovf};
        endcase
    end

    assign z = (y == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first asserted req at or after rr_ptr, wrapping.
// Latency: 0 cycles (pure logic). Backpressure: none, caller qualifies the grant.
// Outputs one-hot grant, encoded index and an any-grant flag.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDW-1:0]     grant_idx,
    output logic               any_grant
);

    always_comb begin
        int idx;
        idx       = 0;
        grant_oh  = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_grant && req[idx]) begin
                any_grant     = 1'b1;
                grant_idx     = IDW'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin grant; optional lock via ALU_ARB_LOCK_EN.
// Latency: accept to rsp_valid is 2 cycles; one operation in flight, 3-cycle minimum occupancy.
// Backpressure: rsp_* held until rsp_ready; no req_ready is raised outside IDLE.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N       = 32,
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    input  logic [NUM_REQ*3-1:0] req_f,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   req_lock,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [N-1:0]         rsp_y,
    output logic                 rsp_o,
    output logic                 rsp_z,
    output logic                 busy
);

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [IDW-1:0]       grant_idx;
    logic                 any_grant;
    logic [IDW-1:0]       rr_ptr, rr_ptr_nxt, ptr_inc;
    logic [N-1:0]         op_a, op_b;
    logic [2:0]           op_f;
    logic [IDW-1:0]       op_id;
    logic [N-1:0]         alu_y;
    logic                 alu_o, alu_z;
    logic                 accept, rsp_hs;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    alu #(.N(N)) u_alu (
        .a (op_a),
        .b (op_b),
        .f (op_f),
        .y (alu_y),
        .o (alu_o),
        .z (alu_z)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_grant) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !reset) req_ready = grant_oh;
        accept = (state == IDLE) && any_grant && !reset;
        rsp_hs = (state == RESP) && rsp_ready;
        busy   = (state != IDLE);
    end

    assign ptr_inc = IDW'(wrap_inc(int'(op_id), NUM_REQ));

`ifdef ALU_ARB_LOCK_EN
    logic [1:0] lock_cnt;
    logic       lock_hold;

    // Lock keeps the pointer on the holder until it has had LOCK_MAX back-to-back grants.
    assign lock_hold = req_lock[op_id] && (lock_cnt < 2'(LOCK_MAX - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt <= '0;
        end else if (rsp_hs) begin
            if (lock_hold) lock_cnt <= (op_id == rr_ptr) ? lock_cnt + 2'd1 : 2'd1;
            else           lock_cnt <= '0;
        end
    end

    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (rsp_hs) rr_ptr_nxt = lock_hold ? op_id : ptr_inc;
    end
`else
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (rsp_hs) rr_ptr_nxt = ptr_inc;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_f      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_o     <= 1'b0;
            rsp_z     <= 1'b0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
            if (accept) begin
                op_a  <= req_a[int'(grant_idx)*N +: N];
                op_b  <= req_b[int'(grant_idx)*N +: N];
                op_f  <= req_f[int'(grant_idx)*3 +: 3];
                op_id <= grant_idx;
            end
            if (state == EXEC) begin
                rsp_y     <= alu_y;
                rsp_o     <= alu_o;
                rsp_z     <= alu_z;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            if (rsp_hs) rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed steps plus a randomized run against a transaction-level model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int N  = 32;
    localparam int NR = 4;

    typedef struct packed {
        logic [31:0] y;
        logic        o;
        logic        z;
    } res_t;

    logic            clk, reset;
    logic [NR-1:0]   req_valid, req_ready;
    logic [NR*N-1:0] req_a, req_b;
    logic [NR*3-1:0] req_f;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_id;
    logic [N-1:0]    rsp_y;
    logic            rsp_o, rsp_z, busy;
`ifdef ALU_ARB_LOCK_EN
    logic [NR-1:0]   req_lock;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int ptr    = 0;

    alu_arbiter #(.N(N), .NUM_REQ(NR), .IDW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_f     (req_f),
`ifdef ALU_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_o     (rsp_o),
        .rsp_z     (rsp_z),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU from signed integer arithmetic.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        res_t   r;
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        r  = '0;
        case (f)
            F_AND: r.y = a & b;
            F_OR:  r.y = a | b;
            F_ADD: s = sa + sb;
            F_SUB: s = sa - sb;
            F_SLT: r.y = (sa < sb) ? 32'd1 : 32'd0;
            default: r.y = '0;
        endcase
        if (f == F_ADD || f == F_SUB) begin
            r.y = s[31:0];
            r.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        r.z = (r.y == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'h7FFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'hFFFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] pick_f();
        logic [2:0] t [5];
        t = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT};
        return t[$urandom_range(0, 4)];
    endfunction

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        req_a[id*N +: N] = a;
        req_b[id*N +: N] = b;
        req_f[id*3 +: 3] = f;
    endtask

    // Lone request from one requester, optional backpressure hold cycles.
    task automatic single(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input int hold);
        res_t e;
        e = model(a, b, f);
        set_req(id, a, b, f);
        req_valid = NR'(1) << id;
        #1;
        chk("single_ready", req_ready, NR'(1) << id);
        tick();
        req_valid = '0;
        req_a = {$urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom};
        req_f = 12'($urandom);
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_no_valid", rsp_valid, 0);
        tick();
        chk("resp_valid", rsp_valid, 1);
        chk("resp_y", rsp_y, e.y);
        chk("resp_o", rsp_o, e.o);
        chk("resp_z", rsp_z, e.z);
        chk("resp_id", rsp_id, id);
        for (int h = 0; h < hold; h++) begin
            req_valid = '1;
            rsp_ready = 1'b0;
            #1;
            chk("bp_ready_low", req_ready, 0);
            tick();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_y", rsp_y, e.y);
            chk("bp_id", rsp_id, id);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("hs_valid_drop", rsp_valid, 0);
        chk("hs_idle", busy, 0);
        ptr = (id + 1) % NR;
    endtask

    initial begin
        res_t        e;
        res_t        fr [NR];
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        logic [NR-1:0] exp_mask;
        int          got, last, win, pid, age;
        bit          have;

        reset = 1'b1;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        req_f = '0;
        rsp_ready = 1'b0;
`ifdef ALU_ARB_LOCK_EN
        req_lock = '0;
`endif
        tick();
        tick();
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_y", rsp_y, 0);
        chk("rst_id", rsp_id, 0);
        reset = 1'b0;
        req_valid = '0;
        ptr = 0;

        single(0, 32'hF0F0_00FF, 32'h0FF0_0F0F, F_AND, 0);
        single(2, 32'hAAAA_AAAA, 32'h5555_5555, F_AND, 5);
        single(3, 32'h7FFF_FFFF, 32'h0000_0001, F_ADD, 1);
        single(1, 32'hFFFF_FFFE, 32'h0000_0003, F_SLT, 0);

        // Reset while an operation is in EXEC.
        set_req(1, 32'h1234_5678, 32'h1111_1111, F_SUB);
        req_valid = 4'b0010;
        tick();
        req_valid = '1;
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", req_ready, 0);
        tick();
        chk("rst_mid_valid", rsp_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_y", rsp_y, 0);
        reset = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_no_rsp", rsp_valid, 0);
        end
        ptr = 0;

        // All requesters valid, consumer always ready: grants 0,1,2,3,0 three cycles apart.
        for (int i = 0; i < NR; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            rf = pick_f();
            set_req(i, ra, rb, rf);
            fr[i] = model(ra, rb, rf);
        end
        req_valid = '1;
        #1;
        chk("fair_first_ready", req_ready, 4'b0001);
        got = 0;
        last = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (rsp_valid) begin
                chk("fair_id", rsp_id, got % NR);
                chk("fair_y", rsp_y, fr[got % NR].y);
                if (got > 0) chk("fair_gap", c - last, 3);
                last = c;
                got++;
            end
            if (got < 5) tick();
        end
        chk("fair_count", got, 5);
        req_valid = '0;
        tick();
        rsp_ready = 1'b0;
        ptr = 1;

`ifdef ALU_ARB_LOCK_EN
        begin
            int exp_ids [6];
            exp_ids = '{0, 1, 1, 1, 1, 2};
            reset = 1'b1;
            tick();
            reset = 1'b0;
            req_lock = 4'b0010;
            req_valid = '1;
            rsp_ready = 1'b1;
            got = 0;
            for (int c = 0; c < 60 && got < 6; c++) begin
                if (rsp_valid) begin
                    chk("lock_id", rsp_id, exp_ids[got]);
                    got++;
                end
                if (got < 6) tick();
            end
            chk("lock_count", got, 6);
            req_valid = '0;
            req_lock = '0;
            tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            rsp_ready = 1'b0;
            ptr = 0;
        end
`endif

        // Randomized traffic against the transaction-level model.
        have = 1'b0;
        pid = 0;
        age = 0;
        e = '0;
        for (int c = 0; c < 600; c++) begin
            req_valid = NR'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) set_req(i, pick_operand(), pick_operand(), pick_f());
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (!have) begin
                win = -1;
                for (int k = 0; k < NR; k++)
                    if (win < 0 && req_valid[(ptr + k) % NR]) win = (ptr + k) % NR;
                exp_mask = '0;
                if (win >= 0) exp_mask[win] = 1'b1;
                chk("rnd_ready", req_ready, exp_mask);
                chk("rnd_idle_valid", rsp_valid, 0);
                if (win >= 0) begin
                    have = 1'b1;
                    age = 0;
                    pid = win;
                    e = model(req_a[win*N +: N], req_b[win*N +: N], req_f[win*3 +: 3]);
                end
            end else begin
                chk("rnd_busy_ready", req_ready, 0);
                if (age >= 2) begin
                    chk("rnd_valid", rsp_valid, 1);
                    chk("rnd_id", rsp_id, pid);
                    chk("rnd_y", rsp_y, e.y);
                    chk("rnd_o", rsp_o, e.o);
                    chk("rnd_z", rsp_z, e.z);
                    if (rsp_ready) begin
                        have = 1'b0;
                        ptr = (pid + 1) % NR;
                    end
                end else begin
                    chk("rnd_exec_valid", rsp_valid, 0);
                end
            end
            tick();
            age++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
